// File: rtl/coord_step_ctrl_pkg.sv
// Types, state encoding and small signed helpers shared by the coordinate step sequencer.
`include "coord_step_ctrl_defs.sv"

package coord_step_ctrl_pkg;

    localparam int unsigned COORD_W = `CSC_COORD_W;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE  = `CSC_ST_IDLE,
        ST_ADD_X = `CSC_ST_ADD_X,
        ST_ADD_Y = `CSC_ST_ADD_Y
    } state_t;

    // Displacement latched when a step is accepted
    typedef struct packed {
        coord_t dx;
        coord_t dy;
    } step_t;

    function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Two's-complement overflow: equal operand signs, result sign differs
    function automatic logic add_ovf(coord_t a, coord_t b, coord_t s);
        return (a[COORD_W-1] == b[COORD_W-1]) && (s[COORD_W-1] != a[COORD_W-1]);
    endfunction

endpackage

// File: rtl/add_coords.sv
// Shared signed coordinate adder; wraps on overflow, caller detects it.
module add_coords
    import coord_step_ctrl_pkg::*;
(
    input  logic signed [COORD_W-1:0] a,
    input  logic signed [COORD_W-1:0] b,
    output logic signed [COORD_W-1:0] sum_c
);

    assign sum_c = a + b;

endmodule

// File: rtl/coord_step_ctrl_defs.sv
// Shared encodings for the coordinate step sequencer: FSM state codes and coordinate width.
`ifndef COORD_STEP_CTRL_DEFS_SV
`define COORD_STEP_CTRL_DEFS_SV

`define CSC_COORD_W  8
`define CSC_ST_IDLE  2'd0
`define CSC_ST_ADD_X 2'd1
`define CSC_ST_ADD_Y 2'd2

`endif

// File: rtl/coord_step_ctrl.sv
// Step/load sequencer for the (x, y) position; one shared adder serves X then Y,
// and the new position commits atomically only when both axes are legal.
module coord_step_ctrl
    import coord_step_ctrl_pkg::*;
#(
    parameter coord_t X_MIN = -8'sd8,
    parameter coord_t X_MAX = 8'sd7,
    parameter coord_t Y_MIN = -8'sd8,
    parameter coord_t Y_MAX = 8'sd7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      step_valid,
    input  logic signed [COORD_W-1:0] step_dx,
    input  logic signed [COORD_W-1:0] step_dy,
    output logic                      step_ready,
    input  logic                      load_valid,
    input  logic signed [COORD_W-1:0] load_x,
    input  logic signed [COORD_W-1:0] load_y,
    output logic signed [COORD_W-1:0] x,
    output logic signed [COORD_W-1:0] y,
    output logic                      done,
    output logic                      oob
);

    state_t state, state_d;
    step_t  step_q, step_d;
    coord_t x_d, y_d, x_nxt, x_nxt_d;
    coord_t add_a, add_b, add_sum;
    logic   ovf_x, ovf_x_d, ovf_y, commit;
    logic   done_d, oob_d;

    assign step_ready = (state == ST_IDLE) && !load_valid;

    add_coords u_add (
        .a     (add_a),
        .b     (add_b),
        .sum_c (add_sum)
    );

    // Adder operand mux: Y operands only in ADD_Y, X operands otherwise
    always_comb begin
        add_a = x;
        add_b = step_q.dx;
        if (state == ST_ADD_Y) begin
            add_a = y;
            add_b = step_q.dy;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state;
        step_d  = step_q;
        x_d     = x;
        y_d     = y;
        x_nxt_d = x_nxt;
        ovf_x_d = ovf_x;
        done_d  = 1'b0;
        oob_d   = 1'b0;
        ovf_y   = 1'b0;
        commit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_valid) begin
                    if (in_range(load_x, X_MIN, X_MAX) && in_range(load_y, Y_MIN, Y_MAX)) begin
                        x_d = load_x;
                        y_d = load_y;
                    end else begin
                        oob_d = 1'b1;
                    end
                end else if (step_valid) begin
                    step_d.dx = step_dx;
                    step_d.dy = step_dy;
                    state_d   = ST_ADD_X;
                end
            end
            ST_ADD_X: begin
                x_nxt_d = add_sum;
                ovf_x_d = add_ovf(add_a, add_b, add_sum);
                state_d = ST_ADD_Y;
            end
            ST_ADD_Y: begin
                ovf_y  = add_ovf(add_a, add_b, add_sum);
                commit = !ovf_x && !ovf_y && in_range(x_nxt, X_MIN, X_MAX)
                         && in_range(add_sum, Y_MIN, Y_MAX);
                if (commit) begin
                    x_d = x_nxt;
                    y_d = add_sum;
                end else begin
                    oob_d = 1'b1;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            step_q <= '0;
            x      <= X_MIN;
            y      <= Y_MIN;
            x_nxt  <= '0;
            ovf_x  <= 1'b0;
            done   <= 1'b0;
            oob    <= 1'b0;
        end else begin
            state  <= state_d;
            step_q <= step_d;
            x      <= x_d;
            y      <= y_d;
            x_nxt  <= x_nxt_d;
            ovf_x  <= ovf_x_d;
            done   <= done_d;
            oob    <= oob_d;
        end
    end

endmodule

// File: doc/coord_step_ctrl.md
# coord_step_ctrl

Sequencer that owns one shared 8-bit signed coordinate adder and time-multiplexes it between the X and Y coordinates. Each accepted step request applies a signed (dx, dy) displacement to the registered position. The new position is bounds-checked against a parameterised window and committed atomically, so X and Y always change together or not at all. It sits between the movement/command logic and every consumer of the current (x, y) position.

## Interface
- X_MIN, default -8: lowest legal X, signed 8-bit.
- X_MAX, default 7: highest legal X, signed 8-bit; X_MIN <= X_MAX.
- Y_MIN, default -8: lowest legal Y, signed 8-bit.
- Y_MAX, default 7: highest legal Y, signed 8-bit; Y_MIN <= Y_MAX.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- step_valid  in  1  step request present.
- step_dx  in  8 signed  X displacement, sampled on acceptance.
- step_dy  in  8 signed  Y displacement, sampled on acceptance.
- step_ready  out  1  combinational: high only in IDLE with load_valid low.
- load_valid  in  1  direct position write request.
- load_x, load_y  in  8 signed each  position to load.
- x, y  out  8 signed each  registered current position.
- done  out  1  registered one-cycle pulse: step finished, committed or rejected.
- oob  out  1  registered one-cycle pulse: step or load rejected as out of bounds.

## Operation
- Reset: x = X_MIN, y = Y_MIN, done = 0, oob = 0, state = IDLE. Internal dx/dy/x_nxt registers clear to 0.
- States: IDLE -> ADD_X -> ADD_Y -> IDLE. There are no other states. Any unreachable encoding returns to IDLE.
- IDLE, load_valid = 1:
  - load has priority and no step is accepted.
  - If X_MIN <= load_x <= X_MAX and Y_MIN <= load_y <= Y_MAX, x and y update on the next edge.
  - Otherwise x and y hold and oob pulses.
  - done does not pulse for a load. State stays IDLE.
- IDLE, step accepted (step_valid & step_ready): latch dx and dy, then go to ADD_X.
- ADD_X:
  - Adder inputs are A = x and B = dx.
  - Register x_nxt = sum and ovf_x = (A[7] == B[7]) & (sum[7] != A[7]).
  - Go to ADD_Y.
- ADD_Y:
  - Adder inputs are A = y and B = dy; compute ovf_y the same way.
  - Commit condition: no ovf_x, no ovf_y, x_nxt within [X_MIN, X_MAX], and the y sum within [Y_MIN, Y_MAX].
  - If the condition holds, write x <= x_nxt and y <= sum. If not, x and y hold and oob <= 1.
  - done <= 1 in either case. Go to IDLE.
- All comparisons are signed 8-bit. Arithmetic wraps in the adder; wrap-around is never committed because the overflow flags force rejection.
- load_valid and step_valid outside IDLE are ignored. Neither is queued.
- Reset asserted mid-step discards the in-flight step immediately: no done, no partial X update.

## Timing
- Latency: step accepted at edge E0 → x_nxt at E1 → x, y, done and oob valid after E2. done is high for exactly the cycle following E2.
- step_ready is low during ADD_X and ADD_Y. It is high again in the done cycle, so a new step can be accepted there. Maximum throughput is one step per 3 cycles.
- A load takes effect one edge after it is sampled in IDLE. oob from a load pulses in that same following cycle.
- done and oob are never held longer than one cycle.

## Structure
- Shared Verilog header (`include): state encodings (IDLE = 2'd0, ADD_X = 2'd1, ADD_Y = 2'd2) and the coordinate width define (8).
- One sub-module: a single instance of the existing coordinate adder (add_coords). Its A and B inputs are muxed by state. There is no second adder.
- Bounds and overflow checks are inline combinational logic in this block.

## Test plan
- Reset with defaults → x = -8, y = -8, done = 0, oob = 0, step_ready = 1.
- Load (0,0), then step (+1,+1) → x = 1, y = 1. done pulses 3 cycles after load (load edge, then accept, E1, E2). oob = 0.
- From (7,0), step (+1,-1) → rejected on the X bound: x = 7, y = 0 unchanged, done = 1 and oob = 1 in the same cycle.
- Parameters X_MAX = 127, Y_MAX = 127. Load (127,5), then step (+1,0) → overflow detected, no wrap to -128, position unchanged, oob pulse.
- load_valid and step_valid high together in IDLE → step_ready = 0, load applied, no done. The step is accepted on the next cycle with load_valid low.
- Step accepted, then rst_n pulled low during ADD_X → x, y return to (X_MIN, Y_MIN), no done pulse, state IDLE after release.
